muldiv_ctrl: RTL and testbench

Sequencer for the HI/LO multiply/divide resource in the P6 five-stage MIPS pipeline. Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and performs MTHI/MTLO writes. Tracks busy state and holds the architectural HI/LO registers. Raises the stall request that freezes any multiply/divide-class instruction in ID while the unit is occupied. Sits in the EX stage beside the ALU; operands arrive already forwarded.

---
 rtl/muldiv_ctrl.sv | 159 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl
//  Brief    : HI/LO multiply/divide sequencer for the EX stage. Holds HI/LO,
//             runs MULT/MULTU/DIV/DIVU over a fixed busy period, performs
//             MTHI/MTLO and raises the ID-stage muldiv stall request.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MDUse_ID,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Stall
);

    localparam logic [2:0] c_opMult  = 3'd0;
    localparam logic [2:0] c_opMultu = 3'd1;
    localparam logic [2:0] c_opDiv   = 3'd2;
    localparam logic [2:0] c_opDivu  = 3'd3;
    localparam logic [2:0] c_opMthi  = 3'd4;
    localparam logic [2:0] c_opMtlo  = 3'd5;

    localparam logic [3:0] c_multCount = 4'(MULT_CYCLES);
    localparam logic [3:0] c_divCount  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_count;
    logic [31:0] r_pendHi;
    logic [31:0] r_pendLo;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // ------------------------------------------------------------------
    // Multiply: one 64-bit multiplier; operands sign- or zero-extended so
    // the low 64 bits of the product are correct for both MULT and MULTU.
    // ------------------------------------------------------------------
    logic        w_mulSigned;
    logic [63:0] w_mulA;
    logic [63:0] w_mulB;
    logic [63:0] w_prod;

    assign w_mulSigned = (MDOp == c_opMult);
    assign w_mulA      = {{32{w_mulSigned & A[31]}}, A};
    assign w_mulB      = {{32{w_mulSigned & B[31]}}, B};
    assign w_prod      = w_mulA * w_mulB;

    // ------------------------------------------------------------------
    // Divide on magnitudes, then restore signs. Working on magnitudes makes
    // 0x80000000 / -1 fall out naturally as quotient 0x80000000, rem 0.
    // ------------------------------------------------------------------
    logic        w_divSigned;
    logic        w_aNeg;
    logic        w_bNeg;
    logic        w_divByZero;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [31:0] w_divisor;
    logic [31:0] w_quotMag;
    logic [31:0] w_remMag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_divSigned = (MDOp == c_opDiv);
    assign w_aNeg      = w_divSigned & A[31];
    assign w_bNeg      = w_divSigned & B[31];
    assign w_divByZero = (B == 32'd0);
    assign w_absA      = w_aNeg ? (32'd0 - A) : A;
    assign w_absB      = w_bNeg ? (32'd0 - B) : B;
    // Divisor forced non-zero so the divider never sees 0; the result is
    // discarded in that case anyway.
    assign w_divisor   = w_divByZero ? 32'd1 : w_absB;
    assign w_quotMag   = w_absA / w_divisor;
    assign w_remMag    = w_absA % w_divisor;
    assign w_quot      = (w_aNeg ^ w_bNeg) ? (32'd0 - w_quotMag) : w_quotMag;
    assign w_rem       = w_aNeg ? (32'd0 - w_remMag) : w_remMag;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= 4'd0;
            r_pendHi <= 32'd0;
            r_pendLo <= 32'd0;
            r_busy   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            c_opMult, c_opMultu: begin
                                r_pendHi <= w_prod[63:32];
                                r_pendLo <= w_prod[31:0];
                                r_count  <= c_multCount;
                                r_busy   <= 1'b1;
                                r_state  <= S_RUN;
                            end
                            c_opDiv, c_opDivu: begin
                                // HI/LO cannot change during RUN, so a divide by
                                // zero simply re-commits their current values.
                                r_pendHi <= w_divByZero ? r_hi : w_rem;
                                r_pendLo <= w_divByZero ? r_lo : w_quot;
                                r_count  <= c_divCount;
                                r_busy   <= 1'b1;
                                r_state  <= S_RUN;
                            end
                            c_opMthi: r_hi <= A;
                            c_opMtlo: r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (r_count == 4'd1) begin
                        r_hi    <= r_pendHi;
                        r_lo    <= r_pendLo;
                        r_count <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_count <= 4'd0;
                end
            endcase
        end
    end

    assign Busy  = r_busy;
    assign HI    = r_hi;
    assign LO    = r_lo;
    // Includes the cycle the op sits in EX so a trailing mfhi/mflo waits.
    assign Stall = MDUse_ID & (Start | r_busy);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_ctrl
//  Brief    : Self-checking bench for muldiv_ctrl against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        MDUse_ID;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Stall;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;
    logic [31:0] mPendHi = 32'd0;
    logic [31:0] mPendLo = 32'd0;
    int          mLeft = 0;

    muldiv_ctrl #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .MDOp    (MDOp),
        .A       (A),
        .B       (B),
        .MDUse_ID(MDUse_ID),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO),
        .Stall   (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Result of an operation from the architectural definition.
    task automatic refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] curHi, input logic [31:0] curLo,
                             output logic [31:0] rHi, output logic [31:0] rLo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        rHi = curHi;
        rLo = curLo;
        case (op)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                rHi = p[63:32];
                rLo = p[31:0];
            end
            3'd1: begin
                p   = {32'd0, a} * {32'd0, b};
                rHi = p[63:32];
                rLo = p[31:0];
            end
            3'd2: if (b != 0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                rLo = q[31:0];
                rHi = r[31:0];
            end
            3'd3: if (b != 0) begin
                rLo = a / b;
                rHi = a % b;
            end
            default: ;
        endcase
    endtask

    // One clock cycle: check outputs, apply inputs, check Stall, advance model.
    task automatic step(input logic iRst, input logic iStart, input logic [2:0] iOp,
                        input logic [31:0] iA, input logic [31:0] iB, input logic iUse);
        logic mBusy;
        @(negedge clk);
        mBusy = (mLeft > 0);
        chk("busy", {31'd0, Busy}, {31'd0, mBusy});
        chk("hi", HI, mHi);
        chk("lo", LO, mLo);
        reset = iRst; Start = iStart; MDOp = iOp; A = iA; B = iB; MDUse_ID = iUse;
        #1;
        chk("stall", {31'd0, Stall}, {31'd0, iUse && (iStart || mBusy)});
        if (iRst) begin
            mHi = 0; mLo = 0; mPendHi = 0; mPendLo = 0; mLeft = 0;
        end else if (mLeft > 0) begin
            mLeft--;
            if (mLeft == 0) begin
                mHi = mPendHi;
                mLo = mPendLo;
            end
        end else if (iStart) begin
            if (iOp <= 3'd3) begin
                refResult(iOp, iA, iB, mHi, mLo, mPendHi, mPendLo);
                mLeft = (iOp <= 3'd1) ? MULT_CYCLES : DIV_CYCLES;
            end else if (iOp == 3'd4) begin
                mHi = iA;
            end else if (iOp == 3'd5) begin
                mLo = iA;
            end
        end
    endtask

    task automatic idle(input int n, input logic use_);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd7, 32'd0, 32'd0, use_);
    endtask

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; Start = 1'b0; MDOp = 3'd7; A = 0; B = 0; MDUse_ID = 1'b0;
        repeat (2) @(posedge clk);

        // MULT -3 * 5 with the ID-stage user present throughout
        step(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
        idle(MULT_CYCLES + 1, 1'b1);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFF1);

        step(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle(MULT_CYCLES + 1, 1'b0);
        chk("multu_hi", HI, 32'h0000_0001);
        chk("multu_lo", LO, 32'hFFFF_FFFE);

        step(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DIV_CYCLES + 1, 1'b0);
        chk("div_hi", HI, 32'hFFFF_FFFF);
        chk("div_lo", LO, 32'hFFFF_FFFD);

        step(1'b0, 1'b1, 3'd3, 32'd7, 32'd2, 1'b0);
        idle(DIV_CYCLES + 1, 1'b0);
        chk("divu_hi", HI, 32'd1);
        chk("divu_lo", LO, 32'd3);

        step(1'b0, 1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DIV_CYCLES + 1, 1'b0);
        chk("divovf_hi", HI, 32'd0);
        chk("divovf_lo", LO, 32'h8000_0000);

        step(1'b0, 1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0);
        idle(1, 1'b0);
        chk("mthi_hi", HI, 32'h1234_5678);
        chk("mthi_busy", {31'd0, Busy}, 32'd0);

        // MTLO while running is ignored
        step(1'b0, 1'b1, 3'd0, 32'd2, 32'd3, 1'b0);
        idle(1, 1'b0);
        step(1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
        idle(MULT_CYCLES - 1, 1'b0);
        chk("mtlo_run_lo", LO, 32'd6);

        // Divide by zero keeps HI/LO
        step(1'b0, 1'b1, 3'd4, 32'hAAAA_0000, 32'd0, 1'b0);
        step(1'b0, 1'b1, 3'd5, 32'h0000_BBBB, 32'd0, 1'b0);
        step(1'b0, 1'b1, 3'd3, 32'd5, 32'd0, 1'b0);
        idle(DIV_CYCLES, 1'b0);
        chk("div0_busy_last", {31'd0, Busy}, 32'd1);
        idle(1, 1'b0);
        chk("div0_hi", HI, 32'hAAAA_0000);
        chk("div0_lo", LO, 32'h0000_BBBB);
        chk("div0_busy_done", {31'd0, Busy}, 32'd0);

        // Reset at busy cycle 3 of a DIV, with a simultaneous Start
        step(1'b0, 1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 1'b1, 3'd0, 32'd9, 32'd9, 1'b0);
        idle(1, 1'b0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        idle(DIV_CYCLES + 2, 1'b0);
        chk("rst_late_hi", HI, 32'd0);
        chk("rst_late_lo", LO, 32'd0);

        // Randomized traffic, including illegal Start during RUN
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
                 3'($urandom_range(0, 7)), pickVal(),
                 ($urandom_range(0, 7) == 0) ? 32'd0 : pickVal(),
                 $urandom_range(0, 1) == 1);
        end
        idle(DIV_CYCLES + 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
